serial_add_sub: RTL and testbench

Bit-serial counterpart of the team's 4-bit ripple add/sub. Operands load in parallel. One bit is processed per clock, LSB first, through a single full-adder slice and a carry flip-flop. The result returns in the same {carry, sum} format as the parallel block. It is intended for area-constrained datapaths where WIDTH+1 cycles of latency are acceptable. It sits behind a start/done handshake.

---
 rtl/serial_add_sub.sv | 132 +++++++++++++
 tb/tb_serial_add_sub.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor behind a start/done handshake.
// Operands load in parallel. One bit per clock, LSB first, passes through a
// single full-adder slice and a carry flip-flop. The result is presented as
// {carry_out, sum} in s_d. Start to done is WIDTH+1 rising edges.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s_d,
  output logic             cout
);

  // The counter is one bit wider than clog2(WIDTH), so it never wraps within
  // an operation, even when WIDTH is a power of two.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg,  a_sr_next;
  logic [WIDTH-1:0] b_sr_reg,  b_sr_next;
  logic [WIDTH-1:0] r_sr_reg,  r_sr_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg,   cnt_next;
  logic [WIDTH:0]   s_d_reg,   s_d_next;

  // Subtraction is A + ~B + 1: B is inverted bit by bit, and the +1 enters
  // through the carry flip-flop when the request is accepted.
  logic [WIDTH-1:0] b_cond;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_b_cond
      assign b_cond[gi] = b[gi] ^ mode;
    end
  endgenerate

  // The single full-adder slice works on the LSBs of the shift registers.
  logic sum_bit;
  logic carry_maj;
  assign sum_bit   = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign carry_maj = (a_sr_reg[0] & b_sr_reg[0]) |
                     (a_sr_reg[0] & carry_reg)   |
                     (b_sr_reg[0] & carry_reg);

  // A request is accepted only when idle or in the single done cycle.
  // A start during RUN is ignored.
  logic accept;
  assign accept = start && (state_reg != RUN);

  // Next-state and datapath logic. Every value defaults to holding.
  always_comb begin
    state_next = state_reg;
    a_sr_next  = a_sr_reg;
    b_sr_next  = b_sr_reg;
    r_sr_next  = r_sr_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    s_d_next   = s_d_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        a_sr_next  = {1'b0, a_sr_reg[WIDTH-1:1]};
        b_sr_next  = {1'b0, b_sr_reg[WIDTH-1:1]};
        r_sr_next  = {sum_bit, r_sr_reg[WIDTH-1:1]};
        carry_next = carry_maj;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST_CNT) begin
          // Publish only the completed word, so s_d never shows partial sums.
          s_d_next   = {carry_maj, sum_bit, r_sr_reg[WIDTH-1:1]};
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Loading is shared by IDLE and DONE, which allows back-to-back requests.
    if (accept) begin
      a_sr_next  = a;
      b_sr_next  = b_cond;
      carry_next = mode;
      cnt_next   = '0;
      r_sr_next  = '0;
    end
  end

  // State register. Reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      r_sr_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_d_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_sr_reg  <= a_sr_next;
      b_sr_reg  <= b_sr_next;
      r_sr_reg  <= r_sr_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      s_d_reg   <= s_d_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign s_d  = s_d_reg;
  assign cout = s_d_reg[WIDTH];

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub against an
// arithmetic reference model (plain +, -, >= on the operands).
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mode;
  logic         busy;
  logic         done;
  logic [W:0]   s_d;
  logic         cout;

  int errors;
  int checks;
  logic [W:0] prev_res;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .s_d   (s_d),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: add gives the full sum. Subtract gives the no-borrow flag
  // on top of a two's-complement difference.
  function automatic logic [W:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic m);
    if (!m) return {1'b0, x} + {1'b0, y};
    else    return {(x >= y), W'(x - y)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. Issues one request and checks each cycle up to
  // and including the done cycle. With poke set, start is re-asserted and the
  // operands are scrambled during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tm, input bit poke);
    logic [W:0] exp;
    exp   = ref_res(ta, tb_v, tm);
    a     = ta;
    b     = tb_v;
    mode  = tm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    mode  = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("run_busy", 64'(busy), 64'(1'b1));
      chk("run_done", 64'(done), 64'(1'b0));
      chk("run_hold", 64'(s_d), 64'(prev_res));
      if (poke) begin
        if (k == 0) begin
          start = 1'b1;
          a     = ~ta;
          b     = ~tb_v;
          mode  = ~tm;
        end
        if (k == W - 1) start = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(1'b1));
    chk("done_busy", 64'(busy), 64'(1'b0));
    chk("result", 64'(s_d), 64'(exp));
    chk("cout", 64'(cout), 64'(exp[W]));
    prev_res = exp;
    $display("op a=%0d b=%0d mode=%0d -> s_d=%b cout=%0d (expected %b)",
             ta, tb_v, tm, s_d, cout, exp);
  endtask

  // One idle cycle after a done, with no new request.
  task automatic idle_chk();
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(1'b0));
    chk("idle_done", 64'(done), 64'(1'b0));
    chk("idle_hold", 64'(s_d), 64'(prev_res));
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    prev_res = '0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    mode     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(1'b0));
    chk("reset_done", 64'(done), 64'(1'b0));
    chk("reset_sd", 64'(s_d), 64'(0));
    chk("reset_cout", 64'(cout), 64'(1'b0));
    rst = 1'b0;

    // Directed cases.
    run_op(4'd5, 4'd3, 1'b0, 1'b0);   idle_chk();
    run_op(4'd7, 4'd3, 1'b1, 1'b0);   idle_chk();
    run_op(4'd3, 4'd7, 1'b1, 1'b0);   idle_chk();
    run_op(4'd15, 4'd15, 1'b0, 1'b0); idle_chk();
    run_op(4'd0, 4'd0, 1'b1, 1'b0);   idle_chk();

    // Back to back: the second request is issued in the done cycle of the first.
    run_op(4'd9, 4'd6, 1'b1, 1'b0);
    run_op(4'd2, 4'd1, 1'b0, 1'b0);   idle_chk();

    // A start and operand changes during RUN are ignored.
    run_op(4'd11, 4'd6, 1'b0, 1'b1);  idle_chk();

    // A reset sampled at edge 2 aborts the operation.
    a = 4'd13; b = 4'd4; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'(1'b0));
    chk("abort_done", 64'(done), 64'(1'b0));
    chk("abort_sd", 64'(s_d), 64'(0));
    chk("abort_cout", 64'(cout), 64'(1'b0));
    rst = 1'b0;
    prev_res = '0;
    repeat (W) begin
      @(negedge clk);
      chk("abort_nodone", 64'(done), 64'(1'b0));
    end
    run_op(4'd6, 4'd9, 1'b1, 1'b0);   idle_chk();

    // When rst and start are high in the same cycle, rst wins.
    a = 4'd1; b = 4'd1; mode = 1'b0; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    prev_res = '0;
    chk("rst_start_busy", 64'(busy), 64'(1'b0));
    chk("rst_start_sd", 64'(s_d), 64'(0));

    // Random requests, with some back to back and some poked during RUN.
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_chk();
    end
    idle_chk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
